// File: rtl/cnn_writer_pkg.sv
// Shared types and status-word layout for the CNN result writer.
// Used by cnn_result_writer and its result FIFO.
package cnn_writer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      ACK    = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH   = 512;
   localparam int STATUS_VALID_BIT = 31;
   localparam int STATUS_TID_MSB   = 30;
   localparam int STATUS_TID_LSB   = 16;
   localparam int STATUS_LINES_MSB = 15;
   localparam int STATUS_LINES_LSB = 0;

   function automatic logic [31:0] mk_status(
      input logic [14:0] tid,
      input logic [15:0] lines
   );
      logic [31:0] s;
      s = '0;
      s[STATUS_VALID_BIT] = 1'b1;
      s[STATUS_TID_MSB:STATUS_TID_LSB] = tid;
      s[STATUS_LINES_MSB:STATUS_LINES_LSB] = lines;
      return s;
   endfunction

endpackage

// File: rtl/cnn_result_writer_result_fifo.sv
// Synchronous result FIFO, 2**AW entries, full/empty flags, no read bypass.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module result_fifo #(
   parameter int W  = 512,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wp_q, rp_q;
   logic         do_push, do_pop;

   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem[rp_q[AW-1:0]];

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wp_q <= '0;
         rp_q <= '0;
      end else if (flush_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/cnn_result_writer.sv
// Buffers CNN result lines and issues them as WrLine requests, then acks.
// Optional cycle counter on perf_cycles: define CNN_RESULT_WRITER_PERF_EN.
module cnn_result_writer
   import cnn_writer_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int LINES_WIDTH = 16,
   parameter int FIFO_AW     = 4
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   enable,
   input  logic                   start,
   input  logic [57:0]            write_base,
   input  logic [LINES_WIDTH-1:0] write_lines,
   input  logic [14:0]            tid,
   input  logic                   res_valid,
   input  logic [DATA_WIDTH-1:0]  res_data,
   output logic                   res_ready,
   input  logic                   wr_almostfull,
   output logic                   wr_valid,
   output logic [57:0]            wr_addr,
   output logic [15:0]            wr_mdata,
   output logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   wr_rsp_valid,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            status_ack,
   output logic [31:0]            perf_cycles
);

   localparam int CW = LINES_WIDTH + 1;

   state_t                state_q, state_d;
   logic [57:0]           base_q;
   logic [CW-1:0]         lines_q;
   logic [14:0]           tid_q;
   logic [CW-1:0]         acc_q, acc_d;
   logic [CW-1:0]         iss_q, iss_d;
   logic [CW-1:0]         rsp_q, rsp_d;
   logic [31:0]           status_q, status_d;
   logic                  af_q;
   logic                  wr_valid_q;
   logic [57:0]           wr_addr_q;
   logic [15:0]           wr_mdata_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  start_go, push, pop, flush;
   logic                  f_full, f_empty;
   logic [DATA_WIDTH-1:0] f_head;

   assign start_go  = enable && start && (state_q == IDLE);
   assign res_ready = enable && (state_q == STREAM) && !f_full &&
                      (acc_q < lines_q);
   assign push      = res_valid && res_ready;
   assign pop       = enable && (state_q == STREAM) && !f_empty && !af_q;

   result_fifo #(
      .W  (DATA_WIDTH),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .resetb  (resetb),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (res_data),
      .pop_i   (pop),
      .rdata_o (f_head),
      .full_o  (f_full),
      .empty_o (f_empty)
   );

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      iss_d    = iss_q;
      rsp_d    = rsp_q;
      status_d = status_q;
      flush    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d    = '0;
               iss_d    = '0;
               rsp_d    = '0;
               status_d = '0;
               if (write_lines == '0) begin
                  state_d  = ACK;
                  status_d = mk_status(tid, 16'(write_lines));
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (push)         acc_d = acc_q + 1'b1;
            if (pop)          iss_d = iss_q + 1'b1;
            if (wr_rsp_valid) rsp_d = rsp_q + 1'b1;
            if (iss_q == lines_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (wr_rsp_valid) rsp_d = rsp_q + 1'b1;
            if (rsp_q == lines_q) begin
               state_d  = ACK;
               status_d = mk_status(tid_q, 16'(lines_q));
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort wins over everything, including a pending start
      if (!enable) begin
         state_d  = IDLE;
         acc_d    = '0;
         iss_d    = '0;
         rsp_d    = '0;
         status_d = status_q;
         flush    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q    <= IDLE;
         base_q     <= '0;
         lines_q    <= '0;
         tid_q      <= '0;
         acc_q      <= '0;
         iss_q      <= '0;
         rsp_q      <= '0;
         status_q   <= '0;
         af_q       <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_mdata_q <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         iss_q      <= iss_d;
         rsp_q      <= rsp_d;
         status_q   <= status_d;
         af_q       <= wr_almostfull;
         wr_valid_q <= pop;
         if (start_go) begin
            base_q  <= write_base;
            lines_q <= CW'(write_lines);
            tid_q   <= tid;
         end
         if (pop) begin
            wr_addr_q  <= base_q + 58'(iss_q);
            wr_mdata_q <= 16'(iss_q);
            wr_data_q  <= f_head;
         end
      end
   end

   assign wr_valid   = wr_valid_q;
   assign wr_addr    = wr_addr_q;
   assign wr_mdata   = wr_mdata_q;
   assign wr_data    = wr_data_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == ACK);
   assign status_ack = status_q;

`ifdef CNN_RESULT_WRITER_PERF_EN
   logic [31:0] cyc_q, perf_q;

   // perf value counts every busy cycle before the ACK cycle
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cyc_q  <= '0;
         perf_q <= '0;
      end else begin
         if (start_go)             cyc_q <= '0;
         else if (state_q != IDLE) cyc_q <= cyc_q + 1'b1;
         if (state_d == ACK && state_q != ACK)
            perf_q <= (state_q == IDLE) ? '0 : cyc_q + 1'b1;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_result_writer.sv
// Self-checking bench for cnn_result_writer: job table, hand sequences, random jobs.
// Scoreboard of expected WrLine requests built from each job's parameters.
module tb_cnn_result_writer;

   localparam int DW = 512;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          resetb, enable, start;
   logic [57:0]   write_base;
   logic [LW-1:0] write_lines;
   logic [14:0]   tid;
   logic          res_valid, res_ready;
   logic [DW-1:0] res_data;
   logic          wr_almostfull, wr_valid, wr_rsp_valid;
   logic [57:0]   wr_addr;
   logic [15:0]   wr_mdata;
   logic [DW-1:0] wr_data;
   logic          busy, done;
   logic [31:0]   status_ack, perf_cycles;

   always #5 clk = ~clk;

   cnn_result_writer dut (
      .clk           (clk),
      .resetb        (resetb),
      .enable        (enable),
      .start         (start),
      .write_base    (write_base),
      .write_lines   (write_lines),
      .tid           (tid),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .res_ready     (res_ready),
      .wr_almostfull (wr_almostfull),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .wr_mdata      (wr_mdata),
      .wr_data       (wr_data),
      .wr_rsp_valid  (wr_rsp_valid),
      .busy          (busy),
      .done          (done),
      .status_ack    (status_ack),
      .perf_cycles   (perf_cycles)
   );

   typedef struct {
      logic [57:0] base;
      logic [15:0] lines;
      logic [14:0] tid;
      int          prod_pct;
      int          af_pct;
      int          rmin;
      int          rmax;
      logic [31:0] st;
   } job_t;

   typedef struct {
      logic [57:0]   a;
      logic [15:0]   m;
      logic [DW-1:0] d;
   } wr_t;

   int tests = 0, fails = 0, cyc = 0;
   logic [DW-1:0] prod_q[$];
   wr_t           exp_q[$];
   int            pend[$];
   int n_wr, n_push, n_done, rsp_sent, first_push, first_wr;
   int done_cyc, start_cyc, busy_cnt, maxocc, cur_lines;
   int prod_pct = 100, af_pct = 0, rmin = 0, rmax = 0;
   bit stall_seen, af_force = 0, inj_rsp = 0, af_p1 = 0, af_p2 = 0, fire = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // monitor, scoreboard, response generator, almost-full driver
   always @(negedge clk) begin
      wr_t e;
      int  due;
      bit  af_now;
      cyc++;
      if (resetb) begin
         if (af_p2) chk("af_gate", wr_valid, 0);
         if (wr_valid) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL wr_unexpected: got mdata %0h want none", wr_mdata);
            end else begin
               e = exp_q.pop_front();
               if (wr_addr !== e.a || wr_mdata !== e.m || wr_data !== e.d) begin
                  fails++;
                  $display("FAIL wr_line: got a=%h m=%h d=%h want a=%h m=%h d=%h",
                           wr_addr, wr_mdata, wr_data[63:0], e.a, e.m, e.d[63:0]);
               end
            end
            due = cyc + $urandom_range(rmax, rmin);
            if (pend.size() > 0 && due <= pend[$]) due = pend[$] + 1;
            pend.push_back(due);
         end
         if (busy && !done) busy_cnt++;
         if (done) begin
            n_done++;
            done_cyc = cyc;
            chk("rsp_at_done", rsp_sent, cur_lines);
         end
      end
      wr_rsp_valid = 1'b0;
      if (inj_rsp) begin
         wr_rsp_valid = 1'b1;
      end else if (pend.size() > 0 && pend[0] <= cyc) begin
         void'(pend.pop_front());
         wr_rsp_valid = 1'b1;
         rsp_sent++;
      end
      af_p2 = af_p1;
      af_now = af_force || ($urandom_range(99, 0) < af_pct);
      wr_almostfull = af_now;
      af_p1 = af_now;
   end

   // accelerator model: presents queued lines, consumes on handshake
   always @(negedge clk) begin
      #2;
      if (fire && prod_q.size() > 0) begin
         void'(prod_q.pop_front());
         n_push++;
      end
      if (n_push - n_wr > maxocc) maxocc = n_push - n_wr;
      if (prod_q.size() > 0 && $urandom_range(99, 0) < prod_pct) begin
         res_valid = 1'b1;
         res_data  = prod_q[0];
      end else begin
         res_valid = 1'b0;
         res_data  = rand_line();
      end
      #2;
      fire = res_valid && res_ready;
      if (fire && first_push < 0) first_push = cyc;
      if (res_valid && !res_ready) stall_seen = 1'b1;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic start_job(input job_t j);
      logic [DW-1:0] d;
      prod_q.delete();
      exp_q.delete();
      pend.delete();
      for (int i = 0; i < int'(j.lines); i++) begin
         d = rand_line();
         prod_q.push_back(d);
         exp_q.push_back('{a: j.base + 58'(i), m: 16'(i), d: d});
      end
      n_wr = 0; n_push = 0; n_done = 0; rsp_sent = 0;
      first_push = -1; first_wr = -1; busy_cnt = 0; maxocc = 0;
      stall_seen = 0;
      prod_pct = j.prod_pct; af_pct = j.af_pct;
      rmin = j.rmin; rmax = j.rmax; cur_lines = int'(j.lines);
      write_base = j.base; write_lines = j.lines; tid = j.tid;
      start = 1'b1;
      start_cyc = cyc;
      step();
      start = 1'b0;
      write_base = {$urandom, $urandom};
      write_lines = LW'($urandom);
      tid = 15'($urandom);
   endtask

   task automatic finish_job(input job_t j);
      int k;
      k = 0;
      while (n_done == 0 && k < 4000) begin
         step();
         k++;
      end
      chk("done_seen", 64'(n_done != 0), 1);
      if (n_done != 0) chk("status", status_ack, j.st);
`ifdef CNN_RESULT_WRITER_PERF_EN
      if (n_done != 0) chk("perf", perf_cycles, busy_cnt);
`endif
      repeat (3) step();
      chk("done_once", n_done, 1);
      chk("n_wr", n_wr, j.lines);
      chk("exp_left", exp_q.size(), 0);
      chk("busy_idle", busy, 0);
      chk("status_hold", status_ack, j.st);
`ifdef CNN_RESULT_WRITER_PERF_EN
      chk("perf_hold", perf_cycles, busy_cnt);
`else
      chk("perf_zero", perf_cycles, 0);
`endif
      if (j.lines != 0 && j.af_pct == 0) chk("latency", first_wr - first_push, 2);
      if (j.lines == 0) chk("zero_done_cyc", done_cyc - start_cyc, 1);
   endtask

   job_t tbl[6];
   job_t j;

   initial begin
      tbl[0] = '{58'h1000, 16'd4, 15'h12, 100, 0, 0, 2, 32'h8012_0004};
      tbl[1] = '{58'h3FF_FFFF_FFFF_FFFF, 16'd2, 15'h7FFF, 100, 0, 1, 4,
                 32'hFFFF_0002};
      tbl[2] = '{58'h0, 16'd0, 15'h55, 100, 0, 0, 0, 32'h8055_0000};
      tbl[3] = '{58'h1_2345_6789, 16'd37, 15'h2AB, 60, 30, 0, 6,
                 32'h82AB_0025};
      tbl[4] = '{58'h2000, 16'd1, 15'h1, 100, 0, 10, 10, 32'h8001_0001};
      tbl[5] = '{58'h3FF_FFFF_FFFF_FFF0, 16'd33, 15'h4000, 80, 20, 0, 20,
                 32'hC000_0021};

      resetb = 1'b0; enable = 1'b0; start = 1'b0;
      write_base = '0; write_lines = '0; tid = '0;
      res_valid = 1'b0; res_data = '0;
      wr_almostfull = 1'b0; wr_rsp_valid = 1'b0;
      cur_lines = 0; first_push = -1; first_wr = -1;
      n_wr = 0; n_push = 0; n_done = 0; rsp_sent = 0;
      repeat (3) step();
      chk("rst_res_ready", res_ready, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status_ack, 0);
      chk("rst_perf", perf_cycles, 0);
      resetb = 1'b1;
      enable = 1'b1;
      repeat (2) step();

      for (int i = 0; i < 6; i++) begin
         start_job(tbl[i]);
         finish_job(tbl[i]);
      end

      // backpressure: almost-full held for 20 cycles on a 20-line run
      j = '{58'h8000, 16'd20, 15'h44, 100, 0, 0, 3, 32'h8044_0014};
      start_job(j);
      af_force = 1'b1;
      repeat (20) step();
      af_force = 1'b0;
      chk("bp_fifo_full", maxocc, 16);
      chk("bp_stall", 64'(stall_seen), 1);
      finish_job(j);

      // abort after 3 issues, then a clean 2-line run from offset 0
      j = '{58'h5000, 16'd8, 15'h3, 100, 0, 200, 200, 32'h0};
      start_job(j);
      for (int k = 0; k < 200 && n_wr < 3; k++) step();
      chk("abort_reach", 64'(n_wr >= 3), 1);
      enable = 1'b0;
      prod_q.delete();
      exp_q.delete();
      step();
      pend.delete();
      chk("abort_busy", busy, 0);
      chk("abort_ready", res_ready, 0);
      repeat (5) step();
      chk("abort_no_done", n_done, 0);
      chk("abort_wr_valid", wr_valid, 0);
      enable = 1'b1;
      step();
      j = '{58'h6000, 16'd2, 15'h9, 100, 0, 0, 3, 32'h8009_0002};
      start_job(j);
      finish_job(j);

      // stray responses in IDLE must not count toward the next run
      inj_rsp = 1'b1;
      repeat (2) step();
      j = '{58'h3FF_FFFF_FFFF_FFFF, 16'd2, 15'h21, 100, 0, 5, 5,
            32'h8021_0002};
      start_job(j);
      inj_rsp = 1'b0;
      finish_job(j);

      for (int r = 0; r < 5; r++) begin
         j.base     = {$urandom, $urandom};
         j.lines    = 16'($urandom_range(40, 0));
         j.tid      = 15'($urandom);
         j.prod_pct = $urandom_range(100, 40);
         j.af_pct   = $urandom_range(40, 0);
         j.rmin     = 0;
         j.rmax     = $urandom_range(12, 0);
         j.st       = {1'b1, j.tid, j.lines};
         start_job(j);
         finish_job(j);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cnn_result_writer.md
Name: cnn_result_writer

Overview:
- Downstream of the read prefetch/re-order stage: the CNN accelerator consumes the buffered weights and image lines, and this block takes its 512-bit result lines.
- Buffers result lines in a small FIFO and issues them as SPL WrLine requests to a host buffer.
- Counts write responses, then emits a done pulse and a 32-bit status word for the DSM update.

Parameters:
- DATA_WIDTH, 512, result/cache-line width in bits
- LINES_WIDTH, 16, width of the line-count and offset counters
- FIFO_AW, 4, log2 of result FIFO depth (16 entries)

Ports:
- clk  in  1  sole clock
- resetb  in  1  asynchronous active-low reset
- enable  in  1  afu_en AND spl_enable; low = synchronous abort
- start  in  1  one-cycle doorbell pulse, sampled only in IDLE
- write_base  in  58  host buffer cache-line address (byte address [63:6])
- write_lines  in  LINES_WIDTH  number of result lines to write
- tid  in  15  transaction id, latched at start
- res_valid  in  1  accelerator result valid
- res_data  in  DATA_WIDTH  accelerator result line
- res_ready  out  1  block accepts res_data this cycle
- wr_almostfull  in  1  SPL write-request channel almost full
- wr_valid  out  1  write request valid (registered)
- wr_addr  out  58  cache-line address = write_base + offset
- wr_mdata  out  16  mdata = line offset
- wr_data  out  DATA_WIDTH  write payload (registered)
- wr_rsp_valid  in  1  one write-completion response
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- status_ack  out  32  {1'b1, tid, write_lines[15:0]}, valid from done onward
- perf_cycles  out  32  see Optional Feature

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; counters 0; FIFO empty.
- States and transitions:
  - IDLE -> STREAM on start, latching write_base, write_lines and tid.
  - IDLE -> ACK if start arrives with write_lines == 0.
  - STREAM -> DRAIN when issued == lines (at most one offset increment per cycle).
  - DRAIN -> ACK when rsp_count == lines.
  - ACK -> IDLE after 1 cycle. done = 1 only in ACK; status_ack is updated on IDLE/DRAIN->ACK and held until the next start.
- enable low, in any state: next cycle IDLE, FIFO flushed, counters cleared, wr_valid 0, no done pulse.
- Accept side:
  - res_ready = (state==STREAM) AND FIFO not full AND accepted < lines.
  - A push occurs on res_valid AND res_ready.
  - res_valid while res_ready is low is not consumed; the accelerator holds its data.
- Issue side:
  - almostfull_ff is wr_almostfull registered by one cycle.
  - A pop occurs when FIFO not empty AND NOT almostfull_ff.
  - The next cycle drives wr_valid=1 with wr_addr=base+issued, wr_mdata=issued, wr_data=head; issued then increments.
  - Latency from an accepted result into an empty FIFO to wr_valid: 2 cycles.
- FIFO simultaneous push and pop: permitted at any occupancy, including full (pop frees the slot) and empty (no bypass; the pop waits one cycle).
- Address arithmetic is 58-bit modulo; the carry out of bit 57 is dropped.
- rsp_count:
  - LINES_WIDTH+1 bits.
  - Increments on wr_rsp_valid only in STREAM or DRAIN; responses in IDLE/ACK are ignored.
  - A response in the same cycle as an issue is counted.
- start while busy: ignored.

Optional Feature:
- Macro: CNN_RESULT_WRITER_PERF_EN.
- Defined:
  - 32-bit cycle counter cleared on the start that leaves IDLE; increments every cycle while busy.
  - Its value is captured into perf_cycles on entry to ACK and held.
- Undefined: perf_cycles tied to 0; no counter logic.

Decomposition:
- Package cnn_writer_pkg:
  - state_t enum {IDLE, STREAM, DRAIN, ACK}, logic [1:0].
  - STATUS_VALID_BIT=31 and the tid/lines field positions of status_ack.
  - Default DATA_WIDTH constant.
- One sub-module: result_fifo, a synchronous FIFO of width DATA_WIDTH and depth 2**FIFO_AW with full/empty flags and no read bypass.

Test Plan:
- Basic run: write_base=0x1000, write_lines=4, tid=0x12, results D0..D3 back-to-back, 4 responses -> wr_addr 0x1000..0x1003, wr_mdata 0..3, data in order; done pulses once; status_ack=0x80120004.
- Backpressure: hold wr_almostfull=1 for 20 cycles during 20-line run -> no wr_valid from the cycle after almostfull rises +1; FIFO fills to 16; res_ready drops; no data loss; all 20 written in order.
- Zero lines: start with write_lines=0 -> done on 2nd cycle after start, no wr_valid, status_ack=0x8000_0000|tid<<16.
- Abort: deassert enable after 3 of 8 issues -> IDLE next cycle, busy=0, no done; a subsequent start with 2 lines completes normally from offset 0.
- Boundary: write_base=0x3FF_FFFF_FFFF_FFFF, 2 lines -> wr_addr wraps to 0x0 on second line; late response in IDLE does not alter next run's count.
- With CNN_RESULT_WRITER_PERF_EN: 1-line run, response returned 10 cycles after issue -> perf_cycles equals the counted busy cycles exactly, stable after done.
